// File: rtl/sys_bus_initiator_if.sv
// Command, response and system-bus signals of sys_bus_initiator.
// master: the initiator; slave: the sequencer plus the register-bus slave.
interface sys_bus_initiator_if #(
    parameter int TW = 16
);
    logic          cmd_valid_i;
    logic          cmd_ready_o;
    logic          cmd_we_i;
    logic [31:0]   cmd_addr_i;
    logic [31:0]   cmd_wdata_i;
    logic [3:0]    cmd_sel_i;

    logic          rsp_valid_o;
    logic          rsp_ready_i;
    logic [31:0]   rsp_rdata_o;
    logic          rsp_err_o;
    logic          rsp_timeout_o;
    logic [TW-1:0] rsp_wait_o;

    logic [31:0]   sys_addr_o;
    logic [31:0]   sys_wdata_o;
    logic [3:0]    sys_sel_o;
    logic          sys_wen_o;
    logic          sys_ren_o;
    logic [31:0]   sys_rdata_i;
    logic          sys_err_i;
    logic          sys_ack_i;

    modport master (
        input  cmd_valid_i, cmd_we_i, cmd_addr_i,
        input  cmd_wdata_i, cmd_sel_i,
        output cmd_ready_o,
        output rsp_valid_o, rsp_rdata_o, rsp_err_o,
        output rsp_timeout_o, rsp_wait_o,
        input  rsp_ready_i,
        output sys_addr_o, sys_wdata_o, sys_sel_o,
        output sys_wen_o, sys_ren_o,
        input  sys_rdata_i, sys_err_i, sys_ack_i
    );

    modport slave (
        output cmd_valid_i, cmd_we_i, cmd_addr_i,
        output cmd_wdata_i, cmd_sel_i,
        input  cmd_ready_o,
        input  rsp_valid_o, rsp_rdata_o, rsp_err_o,
        input  rsp_timeout_o, rsp_wait_o,
        output rsp_ready_i,
        input  sys_addr_o, sys_wdata_o, sys_sel_o,
        input  sys_wen_o, sys_ren_o,
        output sys_rdata_i, sys_err_i, sys_ack_i
    );
endinterface

// File: rtl/sys_bus_initiator.sv
// sys_bus_initiator: single-outstanding command-driven register-bus master.
// Ports: clk_i; rst_i (sync, active-high); bus (master modport: cmd/rsp
//   handshakes and sys_* bus); busy_o (not idle); timeout_cnt_o (saturating
//   count of abandoned accesses).
module sys_bus_initiator #(
    parameter int TIMEOUT = 255,
    parameter int TW      = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    sys_bus_initiator_if.master bus,
    output logic                busy_o,
    output logic [15:0]         timeout_cnt_o
);

    typedef enum logic [1:0] {
        IDLE,
        STROBE,
        WAIT,
        RESP
    } state_t;

    localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT);

    state_t        state;
    logic          we_q;
    logic [TW-1:0] cnt;

    assign busy_o = (state != IDLE);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state             <= IDLE;
            we_q              <= 1'b0;
            cnt               <= '0;
            bus.cmd_ready_o   <= 1'b1;
            bus.rsp_valid_o   <= 1'b0;
            bus.rsp_rdata_o   <= '0;
            bus.rsp_err_o     <= 1'b0;
            bus.rsp_timeout_o <= 1'b0;
            bus.rsp_wait_o    <= '0;
            bus.sys_addr_o    <= '0;
            bus.sys_wdata_o   <= '0;
            bus.sys_sel_o     <= '0;
            bus.sys_wen_o     <= 1'b0;
            bus.sys_ren_o     <= 1'b0;
            timeout_cnt_o     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    // first idle cycle after a response only re-arms ready
                    if (!bus.cmd_ready_o) begin
                        bus.cmd_ready_o <= 1'b1;
                    end else if (bus.cmd_valid_i) begin
                        bus.cmd_ready_o <= 1'b0;
                        bus.sys_addr_o  <= bus.cmd_addr_i;
                        bus.sys_wdata_o <= bus.cmd_wdata_i;
                        bus.sys_sel_o   <= bus.cmd_sel_i;
                        bus.sys_wen_o   <= bus.cmd_we_i;
                        bus.sys_ren_o   <= !bus.cmd_we_i;
                        we_q            <= bus.cmd_we_i;
                        cnt             <= '0;
                        state           <= STROBE;
                    end
                end
                STROBE, WAIT: begin
                    bus.sys_wen_o <= 1'b0;
                    bus.sys_ren_o <= 1'b0;
                    // cnt is 0 in STROBE, so the limit only hits in WAIT;
                    // an ack on the limit cycle still completes normally
                    if (bus.sys_ack_i) begin
                        bus.rsp_valid_o   <= 1'b1;
                        bus.rsp_rdata_o   <= we_q ? '0 : bus.sys_rdata_i;
                        bus.rsp_err_o     <= bus.sys_err_i;
                        bus.rsp_timeout_o <= 1'b0;
                        bus.rsp_wait_o    <= cnt;
                        state             <= RESP;
                    end else if (cnt == LIMIT) begin
                        bus.rsp_valid_o   <= 1'b1;
                        bus.rsp_rdata_o   <= '0;
                        bus.rsp_err_o     <= 1'b1;
                        bus.rsp_timeout_o <= 1'b1;
                        bus.rsp_wait_o    <= cnt;
                        if (timeout_cnt_o != 16'hFFFF) begin
                            timeout_cnt_o <= timeout_cnt_o + 16'd1;
                        end
                        state <= RESP;
                    end else begin
                        cnt   <= cnt + TW'(1);
                        state <= WAIT;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready_i) begin
                        bus.rsp_valid_o <= 1'b0;
                        state           <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sys_bus_initiator.sv
// Randomised self-checking bench for sys_bus_initiator.
// Bus slave and sequencer are modelled here; expectations come from rules.
module tb_sys_bus_initiator;

    localparam int TO = 8;
    localparam int TW = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        busy;
    logic [15:0] tcnt;
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          model_tcnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sys_bus_initiator_if #(.TW(TW)) bus ();

    sys_bus_initiator #(.TIMEOUT(TO), .TW(TW)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .bus          (bus),
        .busy_o       (busy),
        .timeout_cnt_o(tcnt)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        to;
        int          wait_c;
        int          lat;
        int          wen_n;
        int          ren_n;
        int          strobe_k;
        logic        both;
        logic        hold_bad;
        logic        rsp_bad;
        logic        rdy_bad;
        logic        lost;
        int          hs_cyc;
        int          rsp_cyc;
        logic        after_valid;
        logic        after_ready;
    } obs_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        to;
        int          wait_c;
        int          lat;
    } exp_t;

    // Outcome of one access from the bus rules: ack after d cycles
    // completes unless d exceeds the timeout limit.
    function automatic exp_t model(logic we, logic [31:0] rd,
                                   logic err, int d);
        exp_t e;
        if (d <= TO) begin
            e.to     = 1'b0;
            e.err    = err;
            e.rdata  = we ? 32'h0 : rd;
            e.wait_c = d;
        end else begin
            e.to     = 1'b1;
            e.err    = 1'b1;
            e.rdata  = 32'h0;
            e.wait_c = TO;
        end
        e.lat = 2 + e.wait_c;
        if (e.to && model_tcnt < 65535) model_tcnt++;
        return e;
    endfunction

    task automatic run_cmd(input logic we, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [3:0] sel,
                           input int d, input logic ack_hold,
                           input logic err, input logic [31:0] rd,
                           input int rdy_dly, input logic keep_valid,
                           output obs_t o);
        int  k;
        int  n;
        int  vk;
        bit  done;
        o = '{default: 0};
        n = 0;
        while (!bus.cmd_ready_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.cmd_ready_o) begin
            o.lost = 1'b1;
            return;
        end
        bus.cmd_valid_i = 1'b1;
        bus.cmd_we_i    = we;
        bus.cmd_addr_i  = addr;
        bus.cmd_wdata_i = wd;
        bus.cmd_sel_i   = sel;
        @(posedge clk);
        @(negedge clk);
        o.hs_cyc = cyc;
        if (!keep_valid) bus.cmd_valid_i = 1'b0;
        k    = 1;
        vk   = 0;
        done = 0;
        while (!done && k < 100) begin
            if (bus.sys_wen_o) begin
                o.wen_n++;
                o.strobe_k = k;
            end
            if (bus.sys_ren_o) begin
                o.ren_n++;
                o.strobe_k = k;
            end
            if (bus.sys_wen_o && bus.sys_ren_o) o.both = 1'b1;
            if (bus.sys_addr_o !== addr || bus.sys_wdata_o !== wd ||
                bus.sys_sel_o !== sel)
                o.hold_bad = 1'b1;
            if (bus.cmd_ready_o || !busy) o.rdy_bad = 1'b1;
            if (bus.rsp_valid_o) begin
                if (vk == 0) begin
                    o.lat    = k;
                    o.rdata  = bus.rsp_rdata_o;
                    o.err    = bus.rsp_err_o;
                    o.to     = bus.rsp_timeout_o;
                    o.wait_c = int'(bus.rsp_wait_o);
                end else if (o.rdata !== bus.rsp_rdata_o ||
                             o.err !== bus.rsp_err_o ||
                             o.to !== bus.rsp_timeout_o ||
                             o.wait_c != int'(bus.rsp_wait_o)) begin
                    o.rsp_bad = 1'b1;
                end
                vk++;
            end else if (vk != 0) begin
                o.rsp_bad = 1'b1;
            end
            bus.sys_ack_i = ack_hold || (k == 1 + d);
            if (bus.sys_ack_i) begin
                bus.sys_rdata_i = rd;
                bus.sys_err_i   = err;
            end else begin
                bus.sys_rdata_i = $urandom;
                bus.sys_err_i   = 1'($urandom);
            end
            bus.rsp_ready_i = bus.rsp_valid_o && (vk > rdy_dly);
            if (bus.rsp_valid_o && bus.rsp_ready_i) begin
                done      = 1;
                o.rsp_cyc = cyc + 1;
            end else begin
                k++;
                @(negedge clk);
            end
        end
        if (!done) o.lost = 1'b1;
        @(negedge clk);
        bus.rsp_ready_i = 1'b0;
        bus.sys_ack_i   = ack_hold;
        o.after_valid   = bus.rsp_valid_o;
        o.after_ready   = bus.cmd_ready_o;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (bus.cmd_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL rst_cmd_ready got=%b exp=1", bus.cmd_ready_o);
        end
        checks++;
        if (bus.rsp_valid_o !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL rst_valid_busy got=%b%b exp=00",
                     bus.rsp_valid_o, busy);
        end
        checks++;
        if (bus.sys_wen_o !== 1'b0 || bus.sys_ren_o !== 1'b0 ||
            bus.sys_addr_o !== 32'h0 || bus.sys_wdata_o !== 32'h0) begin
            failures++;
            $display("FAIL rst_bus got=%b%b %h %h exp=00 0 0",
                     bus.sys_wen_o, bus.sys_ren_o,
                     bus.sys_addr_o, bus.sys_wdata_o);
        end
        checks++;
        if (tcnt !== 16'h0 || bus.rsp_rdata_o !== 32'h0) begin
            failures++;
            $display("FAIL rst_cnt_rdata got=%h %h exp=0 0",
                     tcnt, bus.rsp_rdata_o);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_read_zero_wait();
        obs_t o;
        exp_t e;
        e = model(1'b0, 32'h1, 1'b0, 0);
        run_cmd(1'b0, 32'h4010_0000, $urandom, 4'hF, 0, 1'b0,
                1'b0, 32'h1, 0, 1'b0, o);
        checks++;
        if (o.lost || o.lat != e.lat) begin
            failures++;
            $display("FAIL rd0_latency got=%0d lost=%b exp=%0d",
                     o.lat, o.lost, e.lat);
        end
        checks++;
        if (o.ren_n != 1 || o.wen_n != 0 || o.strobe_k != 1) begin
            failures++;
            $display("FAIL rd0_strobe got ren=%0d wen=%0d at=%0d exp 1 0 1",
                     o.ren_n, o.wen_n, o.strobe_k);
        end
        checks++;
        if (o.rdata !== e.rdata || o.err !== 1'b0 || o.wait_c != 0) begin
            failures++;
            $display("FAIL rd0_rsp got=%h/%b/%0d exp=%h/0/0",
                     o.rdata, o.err, o.wait_c, e.rdata);
        end
        checks++;
        if (o.after_valid !== 1'b0 || o.after_ready !== 1'b0) begin
            failures++;
            $display("FAIL rd0_handoff got valid=%b ready=%b exp=0 0",
                     o.after_valid, o.after_ready);
        end
    endtask

    task automatic test_write_delayed();
        obs_t o;
        exp_t e;
        logic [31:0] rd;
        rd = $urandom | 32'h1;
        e  = model(1'b1, rd, 1'b0, 3);
        run_cmd(1'b1, 32'h4010_0030, 32'hFE, 4'hF, 3, 1'b0,
                1'b0, rd, 0, 1'b0, o);
        checks++;
        if (o.wen_n != 1 || o.ren_n != 0 || o.strobe_k != 1) begin
            failures++;
            $display("FAIL wr3_strobe got wen=%0d ren=%0d exp=1 0",
                     o.wen_n, o.ren_n);
        end
        checks++;
        if (o.hold_bad) begin
            failures++;
            $display("FAIL wr3_hold got=unstable exp=stable");
        end
        checks++;
        if (o.wait_c != e.wait_c || o.rdata !== e.rdata ||
            o.lat != e.lat) begin
            failures++;
            $display("FAIL wr3_rsp got=%0d/%h/%0d exp=%0d/%h/%0d",
                     o.wait_c, o.rdata, o.lat,
                     e.wait_c, e.rdata, e.lat);
        end
    endtask

    task automatic test_timeout();
        obs_t o;
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            e = model(1'b0, 32'h0, 1'b0, 1000);
            run_cmd(1'b0, $urandom, $urandom, 4'h3, 1000, 1'b0,
                    1'b0, 32'hDEAD_BEEF, 0, 1'b0, o);
            checks++;
            if (o.to !== 1'b1 || o.err !== 1'b1 || o.rdata !== 32'h0 ||
                o.wait_c != e.wait_c || o.lat != e.lat) begin
                failures++;
                $display("FAIL to_rsp got=%b%b %h %0d %0d exp=11 0 %0d %0d",
                         o.to, o.err, o.rdata, o.wait_c, o.lat,
                         e.wait_c, e.lat);
            end
            checks++;
            if (int'(tcnt) != model_tcnt) begin
                failures++;
                $display("FAIL to_count got=%0d exp=%0d", tcnt, model_tcnt);
            end
        end
    endtask

    task automatic test_err_ack();
        obs_t o;
        exp_t e;
        e = model(1'b0, 32'h1234_5678, 1'b1, 2);
        run_cmd(1'b0, 32'h4010_0010, 32'h0, 4'h1, 2, 1'b0,
                1'b1, 32'h1234_5678, 1, 1'b0, o);
        checks++;
        if (o.err !== 1'b1 || o.to !== 1'b0 || o.rdata !== e.rdata) begin
            failures++;
            $display("FAIL err_rsp got=%b%b %h exp=10 %h",
                     o.err, o.to, o.rdata, e.rdata);
        end
        checks++;
        if (int'(tcnt) != model_tcnt) begin
            failures++;
            $display("FAIL err_count got=%0d exp=%0d", tcnt, model_tcnt);
        end
    endtask

    task automatic test_backpressure();
        obs_t o1;
        obs_t o2;
        exp_t e;
        e = model(1'b0, 32'hA5A5_0001, 1'b0, 0);
        run_cmd(1'b0, 32'h4010_0004, 32'h0, 4'hF, 0, 1'b1,
                1'b0, 32'hA5A5_0001, 10, 1'b1, o1);
        checks++;
        if (o1.rsp_bad || o1.rdata !== e.rdata || o1.lat != e.lat) begin
            failures++;
            $display("FAIL bp_rsp got stable=%b %h lat=%0d exp=1 %h %0d",
                     !o1.rsp_bad, o1.rdata, o1.lat, e.rdata, e.lat);
        end
        checks++;
        if (o1.rdy_bad || o1.ren_n != 1 || o1.after_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_block got rdy=%b strobes=%0d exp=0 1",
                     o1.rdy_bad, o1.ren_n);
        end
        e = model(1'b0, 32'hA5A5_0001, 1'b0, 0);
        run_cmd(1'b0, 32'h4010_0004, 32'h0, 4'hF, 0, 1'b1,
                1'b0, 32'hA5A5_0001, 0, 1'b0, o2);
        checks++;
        if (o2.hs_cyc - o1.rsp_cyc != 2 || o2.ren_n != 1) begin
            failures++;
            $display("FAIL bp_next got gap=%0d strobes=%0d exp=2 1",
                     o2.hs_cyc - o1.rsp_cyc, o2.ren_n);
        end
        bus.sys_ack_i = 1'b0;
    endtask

    task automatic test_back_to_back();
        obs_t o1;
        obs_t o2;
        exp_t e;
        e = model(1'b1, 32'h0, 1'b0, 0);
        run_cmd(1'b1, 32'h10, 32'h11, 4'h2, 0, 1'b0,
                1'b0, 32'h0, 0, 1'b0, o1);
        e = model(1'b0, 32'h77, 1'b0, 0);
        run_cmd(1'b0, 32'h20, 32'h22, 4'h4, 0, 1'b0,
                1'b0, 32'h77, 0, 1'b0, o2);
        checks++;
        if (o2.hs_cyc - o1.hs_cyc != 4) begin
            failures++;
            $display("FAIL b2b_interval got=%0d exp=4",
                     o2.hs_cyc - o1.hs_cyc);
        end
        checks++;
        if (o2.rdata !== e.rdata || o2.lat != e.lat) begin
            failures++;
            $display("FAIL b2b_rsp got=%h %0d exp=%h %0d",
                     o2.rdata, o2.lat, e.rdata, e.lat);
        end
    endtask

    task automatic test_reset_in_wait();
        obs_t o;
        exp_t e;
        logic bad;
        int   n;
        n = 0;
        while (!bus.cmd_ready_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        bus.cmd_valid_i = 1'b1;
        bus.cmd_we_i    = 1'b0;
        bus.cmd_addr_i  = 32'h4010_0008;
        bus.sys_ack_i   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid_i = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_tcnt = 0;
        checks++;
        if (bus.cmd_ready_o !== 1'b1 || busy !== 1'b0 ||
            bus.rsp_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL rstw_state got rdy=%b busy=%b vld=%b exp=1 0 0",
                     bus.cmd_ready_o, busy, bus.rsp_valid_o);
        end
        bad = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (bus.rsp_valid_o || bus.sys_ren_o || bus.sys_wen_o)
                bad = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL rstw_quiet got=activity exp=none");
        end
        e = model(1'b0, 32'hCAFE_0001, 1'b0, 1);
        run_cmd(1'b0, 32'h4010_000C, 32'h0, 4'hF, 1, 1'b0,
                1'b0, 32'hCAFE_0001, 0, 1'b0, o);
        checks++;
        if (o.lost || o.rdata !== e.rdata || o.lat != e.lat ||
            tcnt !== 16'h0) begin
            failures++;
            $display("FAIL rstw_next got=%h %0d cnt=%0d exp=%h %0d 0",
                     o.rdata, o.lat, tcnt, e.rdata, e.lat);
        end
    endtask

    task automatic test_random();
        obs_t        o;
        exp_t        e;
        logic        we;
        logic        er;
        logic [31:0] rd;
        logic [31:0] ad;
        logic [31:0] wd;
        logic [3:0]  sl;
        int          d;
        for (int i = 0; i < 40; i++) begin
            we = 1'($urandom);
            er = 1'($urandom);
            rd = $urandom;
            ad = $urandom;
            wd = $urandom;
            sl = 4'($urandom);
            d  = $urandom_range(0, TO + 3);
            e  = model(we, rd, er, d);
            run_cmd(we, ad, wd, sl, d, 1'b0, er, rd,
                    $urandom_range(0, 3), 1'b0, o);
            checks++;
            if (o.lost || o.rdata !== e.rdata || o.err !== e.err ||
                o.to !== e.to || o.wait_c != e.wait_c ||
                o.lat != e.lat) begin
                failures++;
                $display("FAIL rnd_rsp i=%0d d=%0d got=%h %b%b %0d %0d exp=%h %b%b %0d %0d",
                         i, d, o.rdata, o.err, o.to, o.wait_c, o.lat,
                         e.rdata, e.err, e.to, e.wait_c, e.lat);
            end
            checks++;
            if (o.wen_n != int'(we) || o.ren_n != int'(!we) ||
                o.both || o.strobe_k != 1) begin
                failures++;
                $display("FAIL rnd_strobe i=%0d got wen=%0d ren=%0d exp=%0d %0d",
                         i, o.wen_n, o.ren_n, we, !we);
            end
            checks++;
            if (o.hold_bad || o.rsp_bad || o.rdy_bad ||
                o.after_valid !== 1'b0) begin
                failures++;
                $display("FAIL rnd_proto i=%0d got hold=%b rsp=%b rdy=%b exp=000",
                         i, o.hold_bad, o.rsp_bad, o.rdy_bad);
            end
            checks++;
            if (int'(tcnt) != model_tcnt) begin
                failures++;
                $display("FAIL rnd_count i=%0d got=%0d exp=%0d",
                         i, tcnt, model_tcnt);
            end
        end
    endtask

    initial begin
        bus.cmd_valid_i = 1'b0;
        bus.cmd_we_i    = 1'b0;
        bus.cmd_addr_i  = 32'h0;
        bus.cmd_wdata_i = 32'h0;
        bus.cmd_sel_i   = 4'h0;
        bus.rsp_ready_i = 1'b0;
        bus.sys_rdata_i = 32'h0;
        bus.sys_err_i   = 1'b0;
        bus.sys_ack_i   = 1'b0;
        test_reset();
        test_read_zero_wait();
        test_write_delayed();
        test_timeout();
        test_err_ack();
        test_backpressure();
        test_back_to_back();
        test_reset_in_wait();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=stuck exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
